bit_packer: RTL and testbench

BIT_PACKER -- requirements
Module: bit_packer

---
 rtl/bit_packer_pkg.sv | 24 ++
 rtl/bit_packer.sv | 131 +++++++++++++
 tb/tb_bit_packer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_packer_pkg.sv
// Shared compression package.
// Purpose: default widths for the bit packer, the codeword length clamp value
//          and the packer state encoding. Also provides the length clamp helper.
// Contents:
//   ACC_W_DEF  default accumulator width (7 leftover bits + 8 new bits)
//   CNT_W_DEF  default handed-off byte counter width
//   LEN_MAX    largest codeword length; longer requests are clamped to it
//   ST_RUN / ST_DRAIN  packer states
package bit_packer_pkg;

  localparam int ACC_W_DEF = 15;
  localparam int CNT_W_DEF = 16;

  localparam logic [3:0] LEN_MAX = 4'd8;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Lengths above LEN_MAX are treated as LEN_MAX.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

endpackage

// File: rtl/bit_packer.sv
// bit_packer
// Purpose: packs variable-length codewords (0..8 bits, MSB first) into a byte
//          stream. The first received bit lands in OUT[7]. A FLUSH request
//          drains all full bytes and then emits any leftover bits as a final
//          zero-padded byte marked with OUT_LAST.
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   CODE[7:0]  codeword, right-aligned, LEN LSBs meaningful
//   LEN[3:0]   codeword length; 0 is a no-op, >8 is clamped to 8
//   IN_VALID   CODE/LEN valid
//   IN_READY   codeword can be accepted this cycle
//   FLUSH      single-cycle request to emit any partial byte
//   OUT[7:0]   packed byte
//   OUT_VALID  OUT holds a byte
//   OUT_READY  downstream accepts OUT
//   OUT_LAST   OUT is the zero-padded final byte of a flush
//   BYTE_CNT   number of bytes handed off, wrapping
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       CODE,
  input  logic [3:0]       LEN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             FLUSH,
  output logic [7:0]       OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_LAST,
  output logic [CNT_W-1:0] BYTE_CNT
);

  // Accumulator holds its fill bits right-aligned; the oldest bit sits at
  // position r_fill-1. Bits above r_fill are stale and never read.
  logic [ACC_W-1:0] r_acc;
  logic [3:0]       r_fill;
  logic [0:0]       r_state;
  logic [7:0]       r_out;
  logic             r_out_valid;
  logic             r_out_last;
  logic [CNT_W-1:0] r_byte_cnt;

  logic [3:0]       w_len;
  logic [7:0]       w_mask;
  logic [7:0]       w_code_m;
  logic             w_accept;
  logic             w_handoff;
  logic             w_slot_free;
  logic             w_load_full;
  logic             w_load_part;
  logic [7:0]       w_full_byte;
  logic [7:0]       w_part_byte;
  logic [3:0]       w_fill_next;

  assign w_len    = clamp_len(LEN);
  assign w_mask   = 8'((9'd1 << w_len) - 9'd1);
  assign w_code_m = CODE & w_mask;

  assign IN_READY    = (r_state == ST_RUN) && (r_fill < LEN_MAX);
  assign w_accept    = IN_VALID && IN_READY;
  assign w_handoff   = r_out_valid && OUT_READY;
  assign w_slot_free = !r_out_valid || OUT_READY;

  // Full bytes always take priority; the padded tail is only produced in
  // DRAIN once fewer than 8 bits remain.
  assign w_load_full = (r_fill >= LEN_MAX) && w_slot_free;
  assign w_load_part = (r_state == ST_DRAIN) && (r_fill != 4'd0) &&
                       (r_fill < LEN_MAX) && w_slot_free;

  // Oldest 8 bits, and leftover bits moved up to OUT[7] with zero fill.
  assign w_full_byte = 8'(r_acc >> (r_fill - LEN_MAX));
  assign w_part_byte = 8'(r_acc << (LEN_MAX - r_fill));

  // Fill never exceeds 15, so 4-bit modular arithmetic is exact here.
  assign w_fill_next = r_fill + (w_accept ? w_len : 4'd0)
                              - (w_load_full ? LEN_MAX : 4'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc       <= '0;
      r_fill      <= 4'd0;
      r_state     <= ST_RUN;
      r_out       <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_byte_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_acc <= (r_acc << w_len) | ACC_W'(w_code_m);
      end

      r_fill <= w_load_part ? 4'd0 : w_fill_next;

      if (w_load_full) begin
        r_out       <= w_full_byte;
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b0;
      end else if (w_load_part) begin
        r_out       <= w_part_byte;
        r_out_valid <= 1'b1;
        r_out_last  <= 1'b1;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end

      if (w_handoff) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end

      // A flush coinciding with an accept still enters DRAIN; the accepted
      // bits are already counted in the next fill.
      case (r_state)
        ST_RUN:   if (FLUSH) r_state <= ST_DRAIN;
        ST_DRAIN: if (r_fill == 4'd0) r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  assign OUT       = r_out;
  assign OUT_VALID = r_out_valid;
  assign OUT_LAST  = r_out_last;
  assign BYTE_CNT  = r_byte_cnt;

endmodule

// File: tb/tb_bit_packer.sv
module tb_bit_packer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       code;
  logic [3:0]       len;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [7:0]       out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [CNT_W-1:0] byte_cnt;

  bit_packer #(.ACC_W(15), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST_N(rst_n), .CODE(code), .LEN(len), .IN_VALID(in_valid),
    .IN_READY(in_ready), .FLUSH(flush), .OUT(out), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT_LAST(out_last), .BYTE_CNT(byte_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       l;
  } exp_t;

  // Reference model: a plain bit stream and the byte stream it implies.
  bit   bitq[$];
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int hand_cnt = 0;

  logic       prev_hold = 1'b0;
  logic [7:0] prev_out;
  logic       prev_last;
  logic       accepted;
  logic       got_byte;
  logic [7:0] got_val;
  logic       got_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flag(input string tag, input logic ok);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed=timeout/empty expected=event", tag);
    end
  endtask

  function automatic void model_accept(input logic [7:0] c, input logic [3:0] l);
    int n;
    n = (l > 4'd8) ? 8 : int'(l);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(c[i]);
    while (bitq.size() >= 8) begin
      exp_t e;
      e.b = '0;
      for (int i = 7; i >= 0; i--) e.b[i] = bitq.pop_front();
      e.l = 1'b0;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void model_flush();
    if (bitq.size() > 0) begin
      exp_t e;
      int   k;
      e.b = '0;
      k   = 7;
      while (bitq.size() > 0) begin
        e.b[k] = bitq.pop_front();
        k--;
      end
      e.l = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void model_reset();
    bitq.delete();
    exp_q.delete();
    hand_cnt  = 0;
    prev_hold = 1'b0;
  endfunction

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (prev_hold) begin
      chk("hold_out", out, prev_out);
      chk("hold_last", out_last, prev_last);
      chk("hold_valid", out_valid, 1'b1);
    end
    prev_hold = out_valid && !out_ready;
    prev_out  = out;
    prev_last = out_last;
    chk("byte_cnt", byte_cnt, hand_cnt[CNT_W-1:0]);
    if (out_valid && out_ready) begin
      got_byte = 1'b1;
      got_val  = out;
      got_last = out_last;
      chk_flag("byte_expected", exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("byte %0d: out=%02h last=%0b", hand_cnt, out, out_last);
        chk("out_byte", out, e.b);
        chk("out_last", out_last, e.l);
      end
      hand_cnt++;
    end
    if (in_valid && in_ready) begin
      accepted = 1'b1;
      model_accept(code, len);
    end
    if (flush && in_ready) model_flush();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [3:0] l);
    code     = c;
    len      = l;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) cyc();
    in_valid = 1'b0;
    chk_flag("send_accept", accepted);
  endtask

  task automatic do_flush();
    for (int k = 0; k < 40 && !in_ready; k++) cyc();
    chk_flag("flush_ready", in_ready);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] b, input logic l);
    got_byte = 1'b0;
    for (int k = 0; k < 40 && !got_byte; k++) cyc();
    chk_flag({tag, "_seen"}, got_byte);
    chk({tag, "_val"}, got_val, b);
    chk({tag, "_last"}, got_last, l);
  endtask

  initial begin
    rst_n     = 1'b0;
    code      = '0;
    len       = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out", out, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_cnt", byte_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", in_ready, 1'b1);

    // Two full bytes back to back.
    send(8'h42, 4'd8);
    wait_byte("b42", 8'h42, 1'b0);
    send(8'hAE, 4'd8);
    wait_byte("bAE", 8'hAE, 1'b0);
    chk("cnt_two", byte_cnt, 2);

    // Sub-byte codewords combining into one byte.
    send(8'h0A, 4'd4);
    send(8'h05, 4'd4);
    wait_byte("bA5", 8'hA5, 1'b0);
    send(8'h05, 4'd3);
    send(8'h06, 4'd5);
    wait_byte("bA6", 8'hA6, 1'b0);

    // Flush of a 3-bit remainder, then flush with nothing pending.
    send(8'h05, 4'd3);
    do_flush();
    wait_byte("flushA0", 8'hA0, 1'b1);
    chk("run_after_flush", in_ready, 1'b1);
    do_flush();
    chk("drain_empty_ready", in_ready, 1'b0);
    cyc();
    chk("empty_flush_run", in_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("empty_flush_novalid", out_valid, 1'b0);
    end

    // Backpressure: 0x12 held while the next byte stalls in the accumulator.
    out_ready = 1'b0;
    send(8'h01, 4'd4);
    send(8'h02, 4'd4);
    send(8'h03, 4'd4);
    send(8'h04, 4'd4);
    cyc();
    chk("bp_out", out, 8'h12);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    wait_byte("bp12", 8'h12, 1'b0);
    wait_byte("bp34", 8'h34, 1'b0);

    // Reset with a pending byte and 5 leftover bits.
    out_ready = 1'b0;
    send(8'hAB, 4'd8);
    send(8'h1F, 4'd5);
    cyc();
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out, 8'h00);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_last", out_last, 1'b0);
    chk("mid_rst_cnt", byte_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst2", in_ready, 1'b1);
    send(8'hFF, 4'd8);
    wait_byte("bFF", 8'hFF, 1'b0);

    // Zero-length no-op and length clamp.
    send(8'h05, 4'd3);
    send(8'h7F, 4'd0);
    send(8'h06, 4'd5);
    wait_byte("len0", 8'hA6, 1'b0);
    send(8'hC3, 4'd12);
    wait_byte("clamp", 8'hC3, 1'b0);

    // Randomized traffic with occasional flushes and backpressure.
    for (int it = 0; it < 1500; it++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      code      = 8'($urandom);
      len       = 4'($urandom_range(0, 12));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = in_ready && ($urandom_range(0, 15) == 0);
      cyc();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    do_flush();
    for (int k = 0; k < 60 && (exp_q.size() != 0 || out_valid); k++) cyc();
    cyc();
    chk("drained_all", exp_q.size(), 0);
    chk("final_valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
